frame_ingress_parser: RTL and testbench

Ingress stage of the L2 switch, feeding the MAC switching core. It arbitrates round-robin among the four per-port RX FIFOs and splits each received frame into a 115-bit header word and a delimited payload byte stream. The 14 header bytes go into the header FIFO. Payload bytes plus one delimiter entry go into the payload FIFO. Frames are store-and-forward: the header word is written only after the payload delimiter, so the switching core never sees a header whose payload is incomplete.

---
 rtl/frame_ingress_parser.sv | 210 +++++++++++++++++++++
 tb/tb_frame_ingress_parser.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_ingress_parser.sv
`default_nettype none
// ============================================================================
// Module      : frame_ingress_parser
// Description : Round-robin ingress arbiter over four FWFT RX FIFOs. Splits
//               each frame into a 115-bit header word and a delimited payload
//               byte stream. The header is committed only after the payload
//               delimiter (store-and-forward).
// Revision    : 1.0 - initial release
// ============================================================================
module frame_ingress_parser #(
    parameter int MAX_PAYLOAD = 1500
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   p0_rx_data,
    input  logic         p0_rx_del,
    input  logic         p0_rx_empty,
    output logic         p0_rx_rden,
    input  logic [7:0]   p1_rx_data,
    input  logic         p1_rx_del,
    input  logic         p1_rx_empty,
    output logic         p1_rx_rden,
    input  logic [7:0]   p2_rx_data,
    input  logic         p2_rx_del,
    input  logic         p2_rx_empty,
    output logic         p2_rx_rden,
    input  logic [7:0]   p3_rx_data,
    input  logic         p3_rx_del,
    input  logic         p3_rx_empty,
    output logic         p3_rx_rden,
    output logic [114:0] h_fifo_din,
    output logic         h_fifo_wren,
    input  logic         h_fifo_afull,
    output logic [7:0]   b_fifo_din,
    output logic         b_fifo_del,
    output logic         b_fifo_wren,
    input  logic         b_fifo_afull
);

    localparam logic [3:0]  c_LAST_HDR_BYTE = 4'd13;
    localparam logic [10:0] c_MAX_PAY       = 11'(MAX_PAYLOAD);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_PAYLOAD = 3'd2,
        S_COMMIT  = 3'd3,
        S_DROP    = 3'd4
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;

    logic [7:0]   w_rx_data [4];
    logic [3:0]   w_rx_del;
    logic [3:0]   w_rx_empty;
    logic [3:0]   w_rden;

    logic [1:0]   r_rr;
    logic [1:0]   r_sel;
    logic [3:0]   r_byte_cnt;
    logic [10:0]  r_pay_cnt;
    logic         r_oversize;
    logic         r_crc_ok;
    logic [111:0] r_hdr;

    logic [1:0]   w_pick;
    logic         w_any;
    logic         w_start;
    logic         w_pop;
    logic [7:0]   w_cur_data;
    logic         w_cur_del;
    logic         w_cur_empty;

    assign w_rx_data[0] = p0_rx_data;
    assign w_rx_data[1] = p1_rx_data;
    assign w_rx_data[2] = p2_rx_data;
    assign w_rx_data[3] = p3_rx_data;
    assign w_rx_del     = {p3_rx_del, p2_rx_del, p1_rx_del, p0_rx_del};
    assign w_rx_empty   = {p3_rx_empty, p2_rx_empty, p1_rx_empty, p0_rx_empty};

    assign w_cur_data   = w_rx_data[r_sel];
    assign w_cur_del    = w_rx_del[r_sel];
    assign w_cur_empty  = w_rx_empty[r_sel];

    // Pops go only to the selected port and are suppressed while in reset.
    assign w_rden       = (w_pop && rst_n) ? (4'b0001 << r_sel) : 4'b0000;
    assign p0_rx_rden   = w_rden[0];
    assign p1_rx_rden   = w_rden[1];
    assign p2_rx_rden   = w_rden[2];
    assign p3_rx_rden   = w_rden[3];

    // Round-robin scan: first non-empty port starting at r_rr (lowest offset wins).
    always_comb begin
        w_any  = 1'b0;
        w_pick = r_rr;
        for (int i = 3; i >= 0; i--) begin
            if (!w_rx_empty[r_rr + 2'(i)]) begin
                w_any  = 1'b1;
                w_pick = r_rr + 2'(i);
            end
        end
    end

    // Next-state and pop decode.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Both FIFOs must have room reserved before a frame is started.
                if (!h_fifo_afull && !b_fifo_afull && w_any) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_HEADER;
                end
            end
            S_HEADER: begin
                if (!w_cur_empty) begin
                    w_pop = 1'b1;
                    if (w_cur_del) begin
                        w_state_nxt = S_DROP;
                    end else if (r_byte_cnt == c_LAST_HDR_BYTE) begin
                        w_state_nxt = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (!w_cur_empty && !b_fifo_afull) begin
                    w_pop = 1'b1;
                    if (w_cur_del) begin
                        w_state_nxt = S_COMMIT;
                    end
                end
            end
            S_COMMIT: w_state_nxt = S_IDLE;
            S_DROP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: arbitration pointer, header capture, payload/header writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr        <= 2'd0;
            r_sel       <= 2'd0;
            r_byte_cnt  <= 4'd0;
            r_pay_cnt   <= 11'd0;
            r_oversize  <= 1'b0;
            r_crc_ok    <= 1'b0;
            r_hdr       <= '0;
            h_fifo_din  <= '0;
            h_fifo_wren <= 1'b0;
            b_fifo_din  <= 8'h00;
            b_fifo_del  <= 1'b0;
            b_fifo_wren <= 1'b0;
        end else begin
            h_fifo_wren <= 1'b0;
            b_fifo_wren <= 1'b0;
            b_fifo_del  <= 1'b0;

            if (w_start) begin
                r_sel      <= w_pick;
                r_rr       <= w_pick + 2'd1;
                r_byte_cnt <= 4'd0;
                r_pay_cnt  <= 11'd0;
                r_oversize <= 1'b0;
                r_crc_ok   <= 1'b0;
            end

            // Header bytes arrive MSB-first: DST, SRC, TYPE.
            if (w_pop && (r_state == S_HEADER) && !w_cur_del) begin
                r_hdr      <= {r_hdr[103:0], w_cur_data};
                r_byte_cnt <= r_byte_cnt + 4'd1;
            end

            if (w_pop && (r_state == S_PAYLOAD)) begin
                if (w_cur_del) begin
                    b_fifo_wren <= 1'b1;
                    b_fifo_del  <= 1'b1;
                    b_fifo_din  <= 8'h00;
                    r_crc_ok    <= w_cur_data[0];
                end else if (r_pay_cnt < c_MAX_PAY) begin
                    b_fifo_wren <= 1'b1;
                    b_fifo_din  <= w_cur_data;
                    r_pay_cnt   <= r_pay_cnt + 11'd1;
                end else begin
                    // Excess bytes are drained but not forwarded.
                    r_oversize  <= 1'b1;
                end
            end

            if (r_state == S_COMMIT) begin
                h_fifo_wren <= 1'b1;
                h_fifo_din  <= {r_crc_ok & ~r_oversize, r_sel, r_hdr};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_ingress_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_ingress_parser
// Description : Scoreboard bench for frame_ingress_parser. Whole frames are
//               loaded into behavioural RX FIFOs; a frame-level model predicts
//               the service order and the payload/header writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_ingress_parser;

    localparam int MAX_PAYLOAD = 1500;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   p0_rx_data, p1_rx_data, p2_rx_data, p3_rx_data;
    logic         p0_rx_del, p1_rx_del, p2_rx_del, p3_rx_del;
    logic         p0_rx_empty, p1_rx_empty, p2_rx_empty, p3_rx_empty;
    logic         p0_rx_rden, p1_rx_rden, p2_rx_rden, p3_rx_rden;
    logic [114:0] h_fifo_din;
    logic         h_fifo_wren;
    logic         h_fifo_afull;
    logic [7:0]   b_fifo_din;
    logic         b_fifo_del;
    logic         b_fifo_wren;
    logic         b_fifo_afull;

    always #5 clk = ~clk;

    frame_ingress_parser #(.MAX_PAYLOAD(MAX_PAYLOAD)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_rx_data(p0_rx_data), .p0_rx_del(p0_rx_del), .p0_rx_empty(p0_rx_empty), .p0_rx_rden(p0_rx_rden),
        .p1_rx_data(p1_rx_data), .p1_rx_del(p1_rx_del), .p1_rx_empty(p1_rx_empty), .p1_rx_rden(p1_rx_rden),
        .p2_rx_data(p2_rx_data), .p2_rx_del(p2_rx_del), .p2_rx_empty(p2_rx_empty), .p2_rx_rden(p2_rx_rden),
        .p3_rx_data(p3_rx_data), .p3_rx_del(p3_rx_del), .p3_rx_empty(p3_rx_empty), .p3_rx_rden(p3_rx_rden),
        .h_fifo_din(h_fifo_din), .h_fifo_wren(h_fifo_wren), .h_fifo_afull(h_fifo_afull),
        .b_fifo_din(b_fifo_din), .b_fifo_del(b_fifo_del), .b_fifo_wren(b_fifo_wren),
        .b_fifo_afull(b_fifo_afull)
    );

    // Behavioural RX FIFOs: ring buffers of {del, data}.
    logic [8:0]  mem [4][4096];
    logic [11:0] rp [4];
    logic [11:0] wp [4];
    logic        gate;
    logic        flush;
    logic [3:0]  rden;
    logic [3:0]  empt;

    assign rden = {p3_rx_rden, p2_rx_rden, p1_rx_rden, p0_rx_rden};
    assign p0_rx_data = mem[0][rp[0]][7:0];
    assign p1_rx_data = mem[1][rp[1]][7:0];
    assign p2_rx_data = mem[2][rp[2]][7:0];
    assign p3_rx_data = mem[3][rp[3]][7:0];
    assign p0_rx_del  = mem[0][rp[0]][8];
    assign p1_rx_del  = mem[1][rp[1]][8];
    assign p2_rx_del  = mem[2][rp[2]][8];
    assign p3_rx_del  = mem[3][rp[3]][8];
    assign p0_rx_empty = gate || (rp[0] == wp[0]);
    assign p1_rx_empty = gate || (rp[1] == wp[1]);
    assign p2_rx_empty = gate || (rp[2] == wp[2]);
    assign p3_rx_empty = gate || (rp[3] == wp[3]);
    assign empt = {p3_rx_empty, p2_rx_empty, p1_rx_empty, p0_rx_empty};

    always @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (flush) rp[n] <= wp[n];
            else if (rden[n]) rp[n] <= rp[n] + 12'd1;
        end
    end

    int vectors = 0;
    int miscompares = 0;
    int b_wr_seen = 0;
    logic [8:0]   exp_b [$];
    logic [114:0] exp_h [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes either FIFO.
    always @(negedge clk) begin
        if (b_fifo_wren === 1'b1) begin
            b_wr_seen++;
            if (exp_b.size() == 0) fail_now($sformatf("b_unexpected del=%0b din=%0h", b_fifo_del, b_fifo_din));
            else check("b_entry", 128'({b_fifo_del, b_fifo_din}), 128'(exp_b.pop_front()));
        end
        if (h_fifo_wren === 1'b1) begin
            check("wren_exclusive", 128'(b_fifo_wren), 128'(0));
            if (exp_h.size() == 0) fail_now($sformatf("h_unexpected din=%0h", h_fifo_din));
            else check("h_entry", 128'(h_fifo_din), 128'(exp_h.pop_front()));
        end
        if ((|rden) === 1'b1) begin
            check("rden_onehot", 128'($onehot(rden)), 128'(1));
            for (int n = 0; n < 4; n++)
                if (rden[n]) check($sformatf("pop_nonempty_p%0d", n), 128'(empt[n]), 128'(0));
        end
    end

    // Frame records for the current phase.
    int f_port[$], f_start[$], f_len[$];
    bit f_crc[$];
    int m_rr = 0;

    function automatic logic [7:0] plan_byte(input int k);
        if (k < 6)        return 8'(k + 1);
        else if (k < 12)  return 8'(k + 4);
        else if (k == 12) return 8'h08;
        else if (k == 13) return 8'h00;
        else              return 8'(k - 14);
    endfunction

    // nbytes = data entries before the delimiter (header + payload).
    task automatic add_frame(input int port, input int nbytes, input bit crc, input bit plan);
        logic [7:0] b;
        f_port.push_back(port);
        f_start.push_back(int'(wp[port]));
        f_len.push_back(nbytes);
        f_crc.push_back(crc);
        for (int k = 0; k < nbytes; k++) begin
            b = plan ? plan_byte(k) : 8'($urandom);
            mem[port][wp[port]] = {1'b0, b};
            wp[port] = wp[port] + 12'd1;
        end
        mem[port][wp[port]] = {1'b1, 7'h00, crc};
        wp[port] = wp[port] + 12'd1;
    endtask

    // Frame-level model: serve frames round-robin from m_rr, predict writes.
    task automatic predict();
        bit used[$];
        int remaining, idx, port, pay, nwr;
        logic [111:0] hdr;
        bit valid;
        for (int j = 0; j < f_port.size(); j++) used.push_back(1'b0);
        remaining = f_port.size();
        while (remaining > 0) begin
            idx = -1;
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < f_port.size(); j++)
                    if (idx < 0 && !used[j] && f_port[j] == (m_rr + i) % 4) idx = j;
            end
            used[idx] = 1'b1;
            remaining--;
            port = f_port[idx];
            m_rr = (port + 1) % 4;
            if (f_len[idx] >= 14) begin
                hdr = '0;
                for (int k = 0; k < 14; k++)
                    hdr[111 - 8*k -: 8] = mem[port][12'(f_start[idx] + k)][7:0];
                pay = f_len[idx] - 14;
                nwr = (pay > MAX_PAYLOAD) ? MAX_PAYLOAD : pay;
                for (int k = 0; k < nwr; k++)
                    exp_b.push_back({1'b0, mem[port][12'(f_start[idx] + 14 + k)][7:0]});
                exp_b.push_back(9'h100);
                valid = f_crc[idx] && (pay <= MAX_PAYLOAD);
                exp_h.push_back({valid, 2'(port), hdr});
            end
        end
        f_port.delete(); f_start.delete(); f_len.delete(); f_crc.delete();
    endtask

    function automatic bit ports_empty();
        for (int n = 0; n < 4; n++) if (rp[n] != wp[n]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_drain(input bit rnd, input int budget, input string name);
        int cyc = 0;
        int quiet = 0;
        while (quiet < 4 && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            b_fifo_afull = rnd && ($urandom_range(0, 3) == 0);
            h_fifo_afull = rnd && ($urandom_range(0, 4) == 0);
            if (ports_empty() && exp_b.size() == 0 && exp_h.size() == 0) quiet++;
            else quiet = 0;
        end
        b_fifo_afull = 1'b0;
        h_fifo_afull = 1'b0;
        if (cyc >= budget)
            fail_now($sformatf("%s_timeout pending_b=%0d pending_h=%0d", name, exp_b.size(), exp_h.size()));
        gate = 1'b1;
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        int base = b_wr_seen;
        int cyc = 0;
        while (b_wr_seen < base + n && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= budget) fail_now($sformatf("%s_write_timeout", name));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rden"},   128'(rden),        128'(0));
        check({tag, "_h_din"},  128'(h_fifo_din),  128'(0));
        check({tag, "_h_wren"}, 128'(h_fifo_wren), 128'(0));
        check({tag, "_b_din"},  128'(b_fifo_din),  128'(0));
        check({tag, "_b_del"},  128'(b_fifo_del),  128'(0));
        check({tag, "_b_wren"}, 128'(b_fifo_wren), 128'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        gate = 1'b1;
        flush = 1'b1;
        b_fifo_afull = 1'b0;
        h_fifo_afull = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        flush = 1'b0;
        exp_b.delete();
        exp_h.delete();
        m_rr = 0;
    endtask

    task automatic go(input bit rnd, input int budget, input string name);
        predict();
        gate = 1'b0;
        wait_drain(rnd, budget, name);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        for (int n = 0; n < 4; n++) wp[n] = 12'd0;
        do_reset();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reference frame on port 1, good FCS then bad FCS.
        add_frame(1, 14 + 46, 1'b1, 1'b1);
        go(1'b0, 500, "plan_good");
        add_frame(1, 14 + 46, 1'b0, 1'b1);
        go(1'b0, 500, "plan_bad");

        // Runts (10, 13 and 0 bytes) followed by good frames on the same port.
        add_frame(2, 10, 1'b1, 1'b0);
        add_frame(2, 14 + 20, 1'b1, 1'b0);
        add_frame(0, 13, 1'b1, 1'b0);
        add_frame(0, 0, 1'b1, 1'b0);
        add_frame(0, 14 + 5, 1'b1, 1'b0);
        go(1'b0, 500, "runt");

        // Four ports loaded from rr=0, two rounds.
        do_reset();
        rst_n = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < 4; p++) add_frame(p, 14 + 8 + p, 1'b1, 1'b0);
        go(1'b0, 1000, "rr_rounds");

        // Payload length boundaries: 1502, 1500, 1501, 0.
        add_frame(0, 14 + 1502, 1'b1, 1'b0);
        add_frame(1, 14 + 1500, 1'b1, 1'b0);
        add_frame(2, 14 + 1501, 1'b1, 1'b0);
        add_frame(3, 14, 1'b1, 1'b0);
        go(1'b0, 10000, "oversize");

        // Five-cycle payload stall.
        add_frame(0, 14 + 100, 1'b1, 1'b0);
        predict();
        gate = 1'b0;
        wait_writes(10, 200, "stall");
        b_fifo_afull = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("stall_rden", 128'(rden), 128'(0));
            @(posedge clk); #1;
        end
        b_fifo_afull = 1'b0;
        wait_drain(1'b0, 1000, "stall");

        // Reset in the middle of a payload, then a clean frame on the same port.
        add_frame(3, 14 + 200, 1'b1, 1'b0);
        predict();
        gate = 1'b0;
        wait_writes(20, 400, "midreset");
        rst_n = 1'b0;
        gate = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        check_outputs_zero("midreset");
        flush = 1'b0;
        exp_b.delete();
        exp_h.delete();
        m_rr = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        add_frame(3, 14 + 30, 1'b1, 1'b0);
        add_frame(1, 14 + 3, 1'b0, 1'b0);
        go(1'b0, 500, "post_reset");

        // Randomised phases with random back-pressure.
        for (int ph = 0; ph < 12; ph++) begin
            int nfr = $urandom_range(1, 6);
            for (int f = 0; f < nfr; f++) begin
                int kind = $urandom_range(0, 9);
                int len;
                if (kind == 0)      len = $urandom_range(0, 13);
                else if (kind == 1) len = 14;
                else                len = 14 + $urandom_range(1, 64);
                add_frame($urandom_range(0, 3), len, 1'($urandom_range(0, 1)), 1'b0);
            end
            go(1'b1, 3000, $sformatf("random%0d", ph));
        end

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
